// File: rtl/multi_cycle_adder_if.sv
// Start/busy/done handshake and result bundle for the digit-serial adder/subtractor.
interface multi_cycle_adder_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;
   logic             zero;

   modport master (
      output start, sub, a, b,
      input  busy, done, result, carry_out, overflow, zero
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, result, carry_out, overflow, zero
   );
endinterface

// File: rtl/multi_cycle_adder.sv
// Digit-serial adder/subtractor: resolves DIGIT bits per clock through a ripple
// chain of full-adder cells, carrying between digits in a register.
module multi_cycle_adder #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input logic                clk,
   input logic                reset_n,
   multi_cycle_adder_if.slave bus
);
   localparam int STEPS = WIDTH / DIGIT;
   localparam int CNT_W = $clog2(STEPS + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] res_sr;
   logic             carry_reg;
   logic [CNT_W-1:0] step;

   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic             overflow_q;
   logic             zero_q;

   logic [31:0]      base;
   logic [DIGIT-1:0] dig_a;
   logic [DIGIT-1:0] dig_b;
   logic [DIGIT-1:0] dig_sum;
   logic [DIGIT:0]   chain;
   logic [WIDTH-1:0] next_res;
   logic             last_step;
   logic             accept;

   // One digit of the ripple chain; chain[0] is the carry left by the previous digit.
   always_comb begin
      base     = 32'(step) * 32'(DIGIT);
      dig_a    = op_a[base +: DIGIT];
      dig_b    = op_b[base +: DIGIT];
      chain    = '0;
      chain[0] = carry_reg;
      dig_sum  = '0;
      for (int i = 0; i < DIGIT; i++) begin
         dig_sum[i]   = dig_a[i] ^ dig_b[i] ^ chain[i];
         chain[i + 1] = (dig_a[i] & dig_b[i]) | (chain[i] & (dig_a[i] ^ dig_b[i]));
      end
      next_res              = res_sr;
      next_res[base +: DIGIT] = dig_sum;
      last_step = (step == CNT_W'(STEPS - 1));
      accept    = bus.start && (state != RUN);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         op_a       <= '0;
         op_b       <= '0;
         res_sr     <= '0;
         carry_reg  <= 1'b0;
         step       <= '0;
         result_q   <= '0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               // Subtraction is A + ~B + 1, the +1 entering as the first carry-in.
               if (accept) begin
                  op_a      <= bus.a;
                  op_b      <= bus.sub ? ~bus.b : bus.b;
                  carry_reg <= bus.sub;
                  step      <= '0;
                  res_sr    <= '0;
                  state     <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               res_sr    <= next_res;
               carry_reg <= chain[DIGIT];
               step      <= step + CNT_W'(1);
               if (last_step) begin
                  state      <= DONE;
                  result_q   <= next_res;
                  carry_q    <= chain[DIGIT];
                  overflow_q <= chain[DIGIT] ^ chain[DIGIT-1];
                  zero_q     <= (next_res == '0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = (state == RUN);
   assign bus.done      = (state == DONE);
   assign bus.result    = result_q;
   assign bus.carry_out = carry_q;
   assign bus.overflow  = overflow_q;
   assign bus.zero      = zero_q;
endmodule

// File: tb/tb_multi_cycle_adder.sv
// Self-checking bench: three adders (DIGIT 1, 4, 32) run side by side against
// a scoreboard of expected results and completion cycles.
module tb_multi_cycle_adder;
   localparam int STEPS1  = 32;
   localparam int STEPS4  = 8;
   localparam int STEPS32 = 1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start1, start4, start32;
   logic        sub;
   logic [31:0] a, b;
   int          cycle = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   multi_cycle_adder_if #(.WIDTH(32)) bus1 ();
   multi_cycle_adder_if #(.WIDTH(32)) bus4 ();
   multi_cycle_adder_if #(.WIDTH(32)) bus32 ();

   assign bus1.start  = start1;
   assign bus1.sub    = sub;
   assign bus1.a      = a;
   assign bus1.b      = b;
   assign bus4.start  = start4;
   assign bus4.sub    = sub;
   assign bus4.a      = a;
   assign bus4.b      = b;
   assign bus32.start = start32;
   assign bus32.sub   = sub;
   assign bus32.a     = a;
   assign bus32.b     = b;

   multi_cycle_adder #(.WIDTH(32), .DIGIT(1))  dut1  (.clk(clk), .reset_n(reset_n), .bus(bus1));
   multi_cycle_adder #(.WIDTH(32), .DIGIT(4))  dut4  (.clk(clk), .reset_n(reset_n), .bus(bus4));
   multi_cycle_adder #(.WIDTH(32), .DIGIT(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(bus32));

   typedef struct {
      logic [31:0] res;
      logic        c;
      logic        v;
      logic        z;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] res;
      logic        c;
      logic        v;
      logic        z;
   } vec_t;

   exp_t q1[$];
   exp_t q4[$];
   exp_t q32[$];
   exp_t e1, e4, e32;
   int   checks = 0;
   int   passes = 0;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got === want) passes++;
      else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cycle);
   endtask

   task automatic compareDone(input string tag, input exp_t e, input logic [31:0] r,
                              input logic c, input logic v, input logic z, input logic bsy);
      checkOutput({tag, " result"}, r, e.res);
      checkOutput({tag, " carry_out"}, 32'(c), 32'(e.c));
      checkOutput({tag, " overflow"}, 32'(v), 32'(e.v));
      checkOutput({tag, " zero"}, 32'(z), 32'(e.z));
      checkOutput({tag, " busy_in_done"}, 32'(bsy), 32'd0);
      checkOutput({tag, " done_cycle"}, 32'(cycle), 32'(e.cyc));
   endtask

   task automatic unexpectedDone(input string tag);
      checks++;
      $display("[TB] FAIL %s unexpected_done: got done=1, expected no pulse (cycle %0d)", tag, cycle);
   endtask

   always @(negedge clk) begin
      if (bus1.done === 1'b1) begin
         if (q1.size() == 0) unexpectedDone("d1");
         else begin
            e1 = q1.pop_front();
            compareDone("d1", e1, bus1.result, bus1.carry_out, bus1.overflow, bus1.zero, bus1.busy);
         end
      end
   end

   always @(negedge clk) begin
      if (bus4.done === 1'b1) begin
         if (q4.size() == 0) unexpectedDone("d4");
         else begin
            e4 = q4.pop_front();
            compareDone("d4", e4, bus4.result, bus4.carry_out, bus4.overflow, bus4.zero, bus4.busy);
         end
      end
   end

   always @(negedge clk) begin
      if (bus32.done === 1'b1) begin
         if (q32.size() == 0) unexpectedDone("d32");
         else begin
            e32 = q32.pop_front();
            compareDone("d32", e32, bus32.result, bus32.carry_out, bus32.overflow, bus32.zero, bus32.busy);
         end
      end
   end

   function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib, input logic isub);
      exp_t        e;
      logic [31:0] bb;
      logic [32:0] s;
      bb    = isub ? ~ib : ib;
      s     = {1'b0, ia} + {1'b0, bb} + 33'(isub);
      e.res = s[31:0];
      e.c   = s[32];
      e.v   = (ia[31] == bb[31]) && (s[31] != ia[31]);
      e.z   = (s[31:0] == 32'd0);
      e.cyc = 0;
      return e;
   endfunction

   // Called at a falling edge: presents one operation and schedules its expected completion.
   task automatic applyStimulus(input logic [2:0] mask, input logic [31:0] ia, input logic [31:0] ib,
                                input logic isub, input exp_t e);
      exp_t ek;
      a   = ia;
      b   = ib;
      sub = isub;
      ek  = e;
      if (mask[0]) begin ek.cyc = cycle + 1 + STEPS1;  q1.push_back(ek);  start1  = 1'b1; end
      if (mask[1]) begin ek.cyc = cycle + 1 + STEPS4;  q4.push_back(ek);  start4  = 1'b1; end
      if (mask[2]) begin ek.cyc = cycle + 1 + STEPS32; q32.push_back(ek); start32 = 1'b1; end
      @(negedge clk);
      start1  = 1'b0;
      start4  = 1'b0;
      start32 = 1'b0;
   endtask

   task automatic waitAll(input int budget);
      int n = 0;
      while ((q1.size() + q4.size() + q32.size()) != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if ((q1.size() + q4.size() + q32.size()) != 0) begin
         checks++;
         $display("[TB] FAIL timeout: %0d results still pending after %0d cycles, expected 0",
                  q1.size() + q4.size() + q32.size(), budget);
         q1.delete();
         q4.delete();
         q32.delete();
      end
   endtask

   vec_t vecs[8];

   initial begin
      exp_t e;
      vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
      vecs[7] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0};

      reset_n = 1'b0;
      start1  = 1'b0;
      start4  = 1'b0;
      start32 = 1'b0;
      sub     = 1'b0;
      a       = '0;
      b       = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset busy", 32'(bus4.busy), 32'd0);
      checkOutput("reset done", 32'(bus4.done), 32'd0);
      checkOutput("reset result", bus4.result, 32'd0);
      checkOutput("reset flags", {29'd0, bus4.carry_out, bus4.overflow, bus4.zero}, 32'd0);
      reset_n = 1'b1;

      // Directed vectors on all three digit sizes.
      for (int i = 0; i < 8; i++) begin
         e.res = vecs[i].res;
         e.c   = vecs[i].c;
         e.v   = vecs[i].v;
         e.z   = vecs[i].z;
         e.cyc = 0;
         applyStimulus(3'b111, vecs[i].a, vecs[i].b, vecs[i].sub, e);
         waitAll(100);
      end

      // Handshake: start held through RUN is ignored, then accepted in the DONE cycle.
      repeat (2) @(negedge clk);
      a      = 32'd1;
      b      = 32'd1;
      sub    = 1'b0;
      start4 = 1'b1;
      e      = '{32'd2, 1'b0, 1'b0, 1'b0, cycle + 1 + STEPS4};
      q4.push_back(e);
      e      = '{32'd18, 1'b0, 1'b0, 1'b0, cycle + 1 + STEPS4 + 1 + STEPS4};
      q4.push_back(e);
      @(negedge clk);
      checkOutput("hs busy_after_start", 32'(bus4.busy), 32'd1);
      a = 32'd9;
      b = 32'd9;
      repeat (STEPS4) @(negedge clk);
      checkOutput("hs done_pulse", 32'(bus4.done), 32'd1);
      @(negedge clk);
      checkOutput("hs busy_reasserted", 32'(bus4.busy), 32'd1);
      start4 = 1'b0;
      waitAll(50);
      repeat (5) @(negedge clk);
      checkOutput("hold result", bus4.result, 32'd18);
      checkOutput("hold done_low", 32'(bus4.done), 32'd0);

      // Reset in the middle of an operation discards it.
      a      = 32'd100;
      b      = 32'd23;
      sub    = 1'b0;
      start1 = 1'b1;
      start4 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      start4 = 1'b0;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("midrun busy", 32'(bus4.busy), 32'd0);
      checkOutput("midrun done", 32'(bus4.done), 32'd0);
      checkOutput("midrun result", bus4.result, 32'd0);
      checkOutput("midrun flags", {29'd0, bus4.carry_out, bus4.overflow, bus4.zero}, 32'd0);
      checkOutput("midrun d1 result", bus1.result, 32'd0);
      checkOutput("midrun d1 busy", 32'(bus1.busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      e = '{32'd8, 1'b0, 1'b0, 1'b0, 0};
      applyStimulus(3'b111, 32'd5, 32'd3, 1'b0, e);
      waitAll(100);

      // Random sweep across all three digit sizes.
      for (int i = 0; i < 1000; i++) begin
         logic [31:0] ra, rb;
         logic        rs;
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         e  = model(ra, rb, rs);
         applyStimulus(3'b111, ra, rb, rs, e);
         waitAll(100);
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
